lane_ring_buffer: RTL and testbench

Parametrised multi-lane ring buffer that accepts WR_LANES words per write beat and delivers RD_LANES words per read beat, with full valid/ready handshakes on both sides. It replaces the single-lane-out, flag-only first-stage buffer between the DMA burst ingress and the VRSM lane buffers. It adds true occupancy tracking, write backpressure, read-width generalisation and a synchronous flush.

---
 rtl/lane_ring_buffer.sv | 163 ++++++++++++++++
 tb/tb_lane_ring_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_ring_buffer.sv
// ---------------------------------------------------------------------------
// lane_ring_buffer
//
// Multi-lane ring buffer. Each accepted write beat stores WR_LANES words and
// each accepted read beat consumes RD_LANES words. Occupancy is tracked in
// words, so the two sides may use different lane counts.
//
// Optional feature macro: LANE_RING_BUFFER_AFULL_EN
//   When defined, the almost_full output exists and is high while the stored
//   word count is at or above AFULL_LEVEL. When undefined, the port and its
//   logic are absent and AFULL_LEVEL has no effect.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-high reset of pointers and count
//   flush        in   synchronous clear of pointers and count; overrides
//                     any handshake in the same cycle
//   wr_valid     in   write beat offered
//   wr_ready     out  room for a complete beat (from the count register)
//   wr_data      in   WR_LANES words, lane i stored at wptr+i
//   rd_valid     out  at least RD_LANES words stored (from the count register)
//   rd_ready     in   consumer takes rd_data this cycle
//   rd_data      out  RD_LANES words, lane j = storage[rptr+j]
//   level        out  occupancy in words
//   almost_full  out  count >= AFULL_LEVEL (only with the macro)
// ---------------------------------------------------------------------------
module lane_ring_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int WR_LANES     = 4,
    parameter int RD_LANES     = 1,
    parameter int BURST_LENGTH = 128,
    parameter int AFULL_LEVEL  = WR_LANES * BURST_LENGTH - WR_LANES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [WR_LANES*DATA_WIDTH-1:0]         wr_data,
    output logic                                   rd_valid,
    input  logic                                   rd_ready,
    output logic [RD_LANES*DATA_WIDTH-1:0]         rd_data,
    output logic [$clog2(WR_LANES*BURST_LENGTH):0] level
`ifdef LANE_RING_BUFFER_AFULL_EN
    ,
    output logic                                   almost_full
`endif
);

    localparam int DEPTH = WR_LANES * BURST_LENGTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    // Pointer increments wrap naturally; a step equal to DEPTH truncates to 0.
    localparam logic [AW-1:0] WR_STEP = AW'(WR_LANES);
    localparam logic [AW-1:0] RD_STEP = AW'(RD_LANES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] WR_C    = CW'(WR_LANES);
    localparam logic [CW-1:0] RD_C    = CW'(RD_LANES);

    // Illegal geometry stops elaboration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (WR_LANES < 1) || ((WR_LANES & (WR_LANES - 1)) != 0) || (WR_LANES > DEPTH) ||
        (RD_LANES < 1) || ((RD_LANES & (RD_LANES - 1)) != 0) || (RD_LANES > DEPTH)) begin : g_bad_params
        $error("lane_ring_buffer: DEPTH, WR_LANES and RD_LANES must be powers of two with lanes <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wptr_r;
    logic [AW-1:0]         rptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  wr_ready_s;
    logic                  rd_valid_s;
    logic                  wr_fire_s;
    logic                  rd_fire_s;
    logic                  wr_en_s;

    // Handshake status is derived from the count register only, so a read in
    // the same cycle never opens room for a write.
    always_comb begin
        wr_ready_s = ((DEPTH_C - count_r) >= WR_C);
        rd_valid_s = (count_r >= RD_C);
        wr_fire_s  = wr_valid & wr_ready_s;
        rd_fire_s  = rd_valid_s & rd_ready;
        wr_en_s    = wr_fire_s & ~flush;
    end

    // Next occupancy applies both handshakes when they fire together.
    always_comb begin
        count_next_s = count_r;
        if (wr_fire_s) begin
            count_next_s = count_next_s + WR_C;
        end else begin
            count_next_s = count_next_s;
        end
        if (rd_fire_s) begin
            count_next_s = count_next_s - RD_C;
        end else begin
            count_next_s = count_next_s;
        end
    end

    // Pointer and occupancy registers; flush wins over any handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (wr_fire_s) begin
                wptr_r <= wptr_r + WR_STEP;
            end
            if (rd_fire_s) begin
                rptr_r <= rptr_r + RD_STEP;
            end
            count_r <= count_next_s;
        end
    end

    // Word storage, not reset; each write lane lands at wptr+i modulo DEPTH.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < WR_LANES; i++) begin
                mem_r[wptr_r + AW'(i)] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read lanes gather rptr+j modulo DEPTH; content is meaningless while
    // rd_valid is low.
    always_comb begin
        rd_data = {(RD_LANES*DATA_WIDTH){1'b0}};
        for (int j = 0; j < RD_LANES; j++) begin
            rd_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_r[rptr_r + AW'(j)];
        end
    end

    // Output drive from the registered state.
    always_comb begin
        wr_ready = wr_ready_s;
        rd_valid = rd_valid_s;
        level    = count_r;
    end

`ifdef LANE_RING_BUFFER_AFULL_EN
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    // Almost-full threshold compare on the count register.
    always_comb begin
        almost_full = (count_r >= AFULL_C);
    end
`else
    // The threshold parameter has no function in this build.
    logic unused_afull_s;
    assign unused_afull_s = ^AFULL_LEVEL;
`endif

endmodule

// File: tb/tb_lane_ring_buffer.sv
// ---------------------------------------------------------------------------
// tb_lane_ring_buffer
//
// Scoreboard bench: the stimulus side pushes expected read words into queues,
// and monitor processes pop and compare whenever a read beat is taken.
// u_dut uses the default geometry (4 write lanes, 1 read lane, 512 words);
// u_dut4 uses 4 read lanes for the equal-width streaming case.
// ---------------------------------------------------------------------------
module tb_lane_ring_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         wr_valid;
    logic         wr_ready;
    logic [127:0] wr_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [31:0]  rd_data;
    logic [9:0]   level;

    logic         flush4;
    logic         wr_valid4;
    logic         wr_ready4;
    logic [127:0] wr_data4;
    logic         rd_valid4;
    logic         rd_ready4;
    logic [127:0] rd_data4;
    logic [9:0]   level4;
`ifdef LANE_RING_BUFFER_AFULL_EN
    logic         almost_full;
    logic         almost_full4;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q [$];
    logic [127:0] exp4_q [$];
    logic [31:0]  mon_e;
    logic [127:0] mon4_e;
    logic         acc;
    logic [31:0]  base;
    int           beats;
    int           cyc;

    int   exp_lvl [5] = '{512, 511, 510, 509, 508};
    logic exp_wr  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    lane_ring_buffer u_dut (
`ifdef LANE_RING_BUFFER_AFULL_EN
        .almost_full (almost_full),
`endif
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .level    (level)
    );

    lane_ring_buffer #(.RD_LANES(4)) u_dut4 (
`ifdef LANE_RING_BUFFER_AFULL_EN
        .almost_full (almost_full4),
`endif
        .clk      (clk),
        .rst      (rst),
        .flush    (flush4),
        .wr_valid (wr_valid4),
        .wr_ready (wr_ready4),
        .wr_data  (wr_data4),
        .rd_valid (rd_valid4),
        .rd_ready (rd_ready4),
        .rd_data  (rd_data4),
        .level    (level4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic push_beat(input logic [31:0] b);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(b + 32'(k));
        end
    endtask

    // Bounded drain of u_dut with rd_ready held high; ends after a rising edge.
    task automatic drain(input int bound, input string name);
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (n < bound) begin
            @(negedge clk);
            if (!rd_valid) break;
            step();
            n++;
        end
        chk({name, "_in_time"}, 64'(n < bound), 64'd1);
        rd_ready = 1'b0;
        chk({name, "_level"}, 64'(level), 64'd0);
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // Scoreboard monitor for the single-lane read side.
    always @(negedge clk) begin
        if (!rst && !flush && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: got %h with no word expected", rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rd_data !== mon_e) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, mon_e);
                end
            end
        end
    end

    // Scoreboard monitor for the four-lane read side.
    always @(negedge clk) begin
        if (!rst && !flush4 && rd_valid4 && rd_ready4) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data4: got %h with no beat expected", rd_data4);
            end else begin
                mon4_e = exp4_q.pop_front();
                if (rd_data4 !== mon4_e) begin
                    errors++;
                    $display("FAIL rd_data4: got %h expected %h", rd_data4, mon4_e);
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        wr_data   = 128'd0;
        flush4    = 1'b0;
        wr_valid4 = 1'b0;
        rd_ready4 = 1'b0;
        wr_data4  = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
`ifdef LANE_RING_BUFFER_AFULL_EN
        chk("rst_almost_full", 64'(almost_full), 64'd0);
`endif
        step();

        // One beat in, four single words out
        wr_data  = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        wr_valid = 1'b1;
        exp_q.push_back(32'hAAAA_0001);
        exp_q.push_back(32'hBBBB_0002);
        exp_q.push_back(32'hCCCC_0003);
        exp_q.push_back(32'hDDDD_0004);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("one_beat_level", 64'(level), 64'd4);
        chk("one_beat_rd_valid", 64'(rd_valid), 64'd1);
        step();
        rd_ready = 1'b1;
        repeat (4) step();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("one_beat_empty_rd_valid", 64'(rd_valid), 64'd0);
        chk("one_beat_empty_level", 64'(level), 64'd0);
        chk("one_beat_sb_empty", 64'(exp_q.size()), 64'd0);
        step();

        // Fill with 128 back-to-back beats
        for (int b = 0; b < 128; b++) begin
            wr_data  = beat(32'h1000_0000 + 32'(4 * b));
            wr_valid = 1'b1;
            @(negedge clk);
            chk("fill_wr_ready", 64'(wr_ready), 64'd1);
            chk("fill_level", 64'(level), 64'(4 * b));
`ifdef LANE_RING_BUFFER_AFULL_EN
            chk("fill_almost_full", 64'(almost_full), 64'((4 * b) >= 508));
`endif
            push_beat(32'h1000_0000 + 32'(4 * b));
            step();
        end
        // 129th beat offered against a full buffer
        wr_data = beat(32'hDEAD_0000);
        @(negedge clk);
        chk("full_level", 64'(level), 64'd512);
        chk("full_wr_ready", 64'(wr_ready), 64'd0);
        chk("full_rd_valid", 64'(rd_valid), 64'd1);
`ifdef LANE_RING_BUFFER_AFULL_EN
        chk("full_almost_full", 64'(almost_full), 64'd1);
`endif
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("full_hold_level", 64'(level), 64'd512);
        step();

        // Full with simultaneous write offer and read
        wr_data  = beat(32'h5555_0000);
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_rw_level", 64'(level), 64'(exp_lvl[i]));
            chk("full_rw_wr_ready", 64'(wr_ready), 64'(exp_wr[i]));
            if (i == 4) push_beat(32'h5555_0000);
            step();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("full_rw_after_level", 64'(level), 64'd511);
        step();
        drain(1000, "full_drain");

        // Continuous streaming with wrap
        base     = 32'h7000_0000;
        beats    = 0;
        cyc      = 0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        while (beats < 300 && cyc < 5000) begin
            wr_data = beat(base);
            @(negedge clk);
            acc = wr_ready;
            step();
            if (acc) begin
                push_beat(base);
                base  = base + 32'd4;
                beats++;
            end
            cyc++;
        end
        wr_valid = 1'b0;
        chk("stream_beats", 64'(beats), 64'd300);
        drain(2000, "stream_drain");

        // Flush at level 200 with a write offered
        for (int b = 0; b < 50; b++) begin
            wr_data  = beat(32'h9000_0000 + 32'(4 * b));
            wr_valid = 1'b1;
            push_beat(32'h9000_0000 + 32'(4 * b));
            step();
        end
        wr_data = beat(32'hBAD0_0000);
        flush   = 1'b1;
        @(negedge clk);
        chk("flush_cycle_level", 64'(level), 64'd200);
        chk("flush_cycle_rd_valid", 64'(rd_valid), 64'd1);
        chk("flush_cycle_wr_ready", 64'(wr_ready), 64'd1);
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_flush_level", 64'(level), 64'd0);
        chk("post_flush_rd_valid", 64'(rd_valid), 64'd0);
        chk("post_flush_wr_ready", 64'(wr_ready), 64'd1);
        step();
        wr_data  = beat(32'h6000_0000);
        wr_valid = 1'b1;
        push_beat(32'h6000_0000);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_first_word", 64'(rd_data), 64'h6000_0000);
        chk("post_flush_write_level", 64'(level), 64'd4);
        step();
        drain(20, "flush_drain");

        // Four read lanes: write and read every cycle
        wr_data4  = beat(32'h3000_0000);
        wr_valid4 = 1'b1;
        exp4_q.push_back(beat(32'h3000_0000));
        step();
        rd_ready4 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wr_data4 = beat(32'h3000_0000 + 32'(4 * k));
            exp4_q.push_back(beat(32'h3000_0000 + 32'(4 * k)));
            @(negedge clk);
            chk("rw4_level", 64'(level4), 64'd4);
            step();
        end
        wr_valid4 = 1'b0;
        step();
        rd_ready4 = 1'b0;
        @(negedge clk);
        chk("rw4_end_level", 64'(level4), 64'd0);
        chk("rw4_end_rd_valid", 64'(rd_valid4), 64'd0);
        chk("rw4_sb_empty", 64'(exp4_q.size()), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
